formula_1_arg_throttle: RTL and testbench

Upstream feeder for the single-isqrt formula 1 datapath (sqrt(a) + sqrt(b) + sqrt(c)). It accepts (a, b, c) argument triples from a valid/ready producer and buffers them in a small FIFO. It then issues them on the `arg_vld`/`a`/`b`/`c` port of the pipe-aware FSM no more often than once every `ISSUE_PERIOD` cycles. This spacing is the minimum the FSM tolerates when it time-shares one pipelined isqrt (N+3 cycles for an N-stage isqrt).

---
 rtl/formula_1_arg_throttle.sv | 112 +++++++++++
 tb/tb_formula_1_arg_throttle.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/formula_1_arg_throttle.sv
// rtl/formula_1_arg_throttle.sv - argument FIFO and issue-rate throttle for the formula 1 datapath
//
// Buffers (a, b, c) triples from a valid/ready producer and issues them to the
// formula FSM as one-cycle arg_vld pulses spaced at least ISSUE_PERIOD cycles apart.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-low reset
//   in_vld      producer has a triple on in_a/in_b/in_c
//   in_rdy      a triple can be accepted this cycle (FIFO not full)
//   in_a/b/c    incoming triple, 32 bits each
//   arg_vld     one-cycle issue pulse (registered)
//   a/b/c       issued triple; holds last issued value while arg_vld=0
//   fifo_level  number of stored triples
//   busy        FIFO non-empty or cooldown running
module formula_1_arg_throttle #(
    parameter int ISSUE_PERIOD = 19,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_vld,
    output logic                          in_rdy,
    input  logic [31:0]                   in_a,
    input  logic [31:0]                   in_b,
    input  logic [31:0]                   in_c,
    output logic                          arg_vld,
    output logic [31:0]                   a,
    output logic [31:0]                   b,
    output logic [31:0]                   c,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(ISSUE_PERIOD) + 1;

    logic [95:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [CW-1:0] r_cool;
    logic          r_arg_vld;
    logic [95:0]   r_arg;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Full is decoded only from registered level: a pop in the same cycle
    // never opens a slot for the producer until the following edge.
    assign w_full  = (r_level == LW'(FIFO_DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = in_vld && !w_full;
    // Pop only from registered state, so a triple written this edge into an
    // empty FIFO is issued no earlier than the next edge.
    assign w_pop   = !w_empty && (r_cool == '0);

    // Storage carries no reset; validity is tracked by the level counter.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_a, in_b, in_c};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_cool    <= '0;
            r_arg_vld <= 1'b0;
            r_arg     <= '0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase

            if (w_pop) begin
                r_cool <= CW'(ISSUE_PERIOD - 1);
            end else if (r_cool != '0) begin
                r_cool <= r_cool - CW'(1);
            end

            r_arg_vld <= w_pop;
            if (w_pop) begin
                r_arg <= r_mem[r_rd_ptr];
            end
        end
    end

    assign in_rdy     = !w_full;
    assign arg_vld    = r_arg_vld;
    assign a          = r_arg[95:64];
    assign b          = r_arg[63:32];
    assign c          = r_arg[31:0];
    assign fifo_level = r_level;
    assign busy       = !w_empty || (r_cool != '0);

endmodule

// File: tb/tb_formula_1_arg_throttle.sv
// tb/tb_formula_1_arg_throttle.sv - self-checking bench for formula_1_arg_throttle
module tb_formula_1_arg_throttle;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_vld = 1'b0;
    logic [31:0] in_a = '0, in_b = '0, in_c = '0;

    logic        rdy0, vld0, busy0, rdy1, vld1, busy1;
    logic [31:0] a0, b0, c0, a1, b1, c1;
    logic [2:0]  lvl0, lvl1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    formula_1_arg_throttle #(.ISSUE_PERIOD(19), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(rdy0),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .arg_vld(vld0), .a(a0), .b(b0), .c(c0),
        .fifo_level(lvl0), .busy(busy0)
    );

    formula_1_arg_throttle #(.ISSUE_PERIOD(1), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(rdy1),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .arg_vld(vld1), .a(a1), .b(b1), .c(c1),
        .fifo_level(lvl1), .busy(busy1)
    );

    // Reference model: a queue of pending triples, an integer cooldown and
    // the last issued pulse/value, one set per DUT instance.
    logic [95:0] q0[$];
    logic [95:0] q1[$];
    int          cd[2];
    bit          mv[2];
    logic [95:0] mo[2];

    function automatic int period(input int k);
        return (k == 0) ? 19 : 1;
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            cd[k] = 0;
            mv[k] = 0;
            mo[k] = '0;
        end
    endtask

    task automatic model_step(input int k, input bit v, input logic [95:0] d);
        int sz;
        sz = qsize(k);
        if (sz != 0 && cd[k] == 0) begin
            mv[k] = 1;
            if (k == 0) mo[k] = q0.pop_front();
            else        mo[k] = q1.pop_front();
            cd[k] = period(k) - 1;
        end else begin
            mv[k] = 0;
            if (cd[k] > 0) cd[k] = cd[k] - 1;
        end
        if (v && sz != DEPTH) begin
            if (k == 0) q0.push_back(d);
            else        q1.push_back(d);
        end
    endtask

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input int k);
        int sz;
        sz = qsize(k);
        if (k == 0) begin
            chk("d0_rdy",   96'(rdy0), 96'(sz != DEPTH));
            chk("d0_vld",   96'(vld0), 96'(mv[0]));
            chk("d0_data",  {a0, b0, c0}, mo[0]);
            chk("d0_level", 96'(lvl0), 96'(sz));
            chk("d0_busy",  96'(busy0), 96'(sz != 0 || cd[0] != 0));
        end else begin
            chk("d1_rdy",   96'(rdy1), 96'(sz != DEPTH));
            chk("d1_vld",   96'(vld1), 96'(mv[1]));
            chk("d1_data",  {a1, b1, c1}, mo[1]);
            chk("d1_level", 96'(lvl1), 96'(sz));
            chk("d1_busy",  96'(busy1), 96'(sz != 0 || cd[1] != 0));
        end
    endtask

    // Called at a negedge: drive inputs for one cycle, advance the model
    // across the coming rising edge, then compare at the next negedge.
    task automatic step(input bit v, input logic [95:0] d);
        in_vld = v;
        {in_a, in_b, in_c} = d;
        model_step(0, v, d);
        model_step(1, v, d);
        @(posedge clk);
        @(negedge clk);
        check_dut(0);
        check_dut(1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        check_dut(0);
        check_dut(1);
    endtask

    function automatic logic [95:0] trip(input int i);
        return {32'(i * 3 + 1), 32'(i * 5 + 2), 32'(i * 7 + 3)};
    endfunction

    typedef struct {
        bit          v;
        logic [95:0] d;
        bit          e_rdy;
        bit          e_vld;
        logic [95:0] e_data;
        int          e_level;
        bit          e_busy;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic [95:0] issued[$];
        int          issue_at[$];
        int          max_lvl;
        int          idx;
        int          guard;
        int          pulses;
        bit          v;
        logic [95:0] d;

        // Single triple (4, 9, 16) from idle on the ISSUE_PERIOD=19 instance.
        tbl[0] = '{1, {32'd4, 32'd9, 32'd16}, 1, 0, 96'd0, 1, 1};
        tbl[1] = '{0, 96'd0, 1, 1, {32'd4, 32'd9, 32'd16}, 0, 1};
        for (int i = 2; i < 19; i++)
            tbl[i] = '{0, 96'd0, 1, 0, {32'd4, 32'd9, 32'd16}, 0, 1};
        tbl[19] = '{0, 96'd0, 1, 0, {32'd4, 32'd9, 32'd16}, 0, 0};

        // Reset state
        do_reset();
        chk("rst_rdy",   96'(rdy0), 96'd1);
        chk("rst_vld",   96'(vld0), 96'd0);
        chk("rst_level", 96'(lvl0), 96'd0);
        chk("rst_busy",  96'(busy0), 96'd0);
        chk("rst_data",  {a0, b0, c0}, 96'd0);

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].v, tbl[i].d);
            chk($sformatf("tbl%0d_rdy", i),   96'(rdy0), 96'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_vld", i),   96'(vld0), 96'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_data", i),  {a0, b0, c0}, tbl[i].e_data);
            chk($sformatf("tbl%0d_level", i), 96'(lvl0), 96'(tbl[i].e_level));
            chk($sformatf("tbl%0d_busy", i),  96'(busy0), 96'(tbl[i].e_busy));
        end

        // Burst of 4: level peaks at 3, issues exactly 19 cycles apart, in order.
        do_reset();
        max_lvl = 0;
        issued.delete();
        issue_at.delete();
        for (int s = 0; s < 66; s++) begin
            step(s < 4, trip(s));
            if (int'(lvl0) > max_lvl) max_lvl = int'(lvl0);
            if (vld0) begin
                issued.push_back({a0, b0, c0});
                issue_at.push_back(s);
            end
        end
        chk("b4_peak",  96'(max_lvl), 96'd3);
        chk("b4_count", 96'(issued.size()), 96'd4);
        for (int i = 0; i < issued.size() && i < 4; i++)
            chk($sformatf("b4_data%0d", i), issued[i], trip(i));
        for (int i = 1; i < issue_at.size(); i++)
            chk($sformatf("b4_gap%0d", i), 96'(issue_at[i] - issue_at[i-1]), 96'd19);

        // Burst of 6 with a producer that holds until accepted and scrambles
        // data while in_rdy is low.
        do_reset();
        idx = 0;
        issued.delete();
        for (int s = 0; s < 110; s++) begin
            v = (idx < 6);
            d = rdy0 ? trip(idx + 10) : {$urandom, $urandom, $urandom};
            if (v && rdy0) begin
                step(v, d);
                idx++;
            end else begin
                step(v, d);
            end
            if (s == 4)  chk("b6_full_l4",  96'(lvl0), 96'd4);
            if (s == 5)  chk("b6_full_rdy", 96'(rdy0), 96'd0);
            if (s == 20) chk("b6_pop_l3",   96'(lvl0), 96'd3);
            if (s == 21) chk("b6_refill_l4", 96'(lvl0), 96'd4);
            if (vld0) issued.push_back({a0, b0, c0});
        end
        chk("b6_count", 96'(issued.size()), 96'd6);
        for (int i = 0; i < issued.size() && i < 6; i++)
            chk($sformatf("b6_data%0d", i), issued[i], trip(i + 10));

        // ISSUE_PERIOD=1: eight back-to-back triples give eight continuous pulses.
        do_reset();
        for (int s = 0; s < 13; s++) begin
            step(s < 8, trip(s + 20));
            chk($sformatf("p1_vld%0d", s), 96'(vld1), 96'(s >= 1 && s <= 8));
            if (s >= 1 && s <= 8)
                chk($sformatf("p1_data%0d", s), {a1, b1, c1}, trip(s + 19));
        end

        // Asynchronous reset with 3 queued and cooldown at 10.
        do_reset();
        for (int s = 0; s < 4; s++) step(1'b1, trip(s + 40));
        step(1'b0, '0);
        guard = 0;
        while (cd[0] != 10 && guard < 40) begin
            step(1'b0, '0);
            guard++;
        end
        chk("ar_cd_reached", 96'(guard < 40), 96'd1);
        chk("ar_pre_level", 96'(lvl0), 96'd3);
        chk("ar_pre_busy",  96'(busy0), 96'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_vld",   96'(vld0), 96'd0);
        chk("ar_level", 96'(lvl0), 96'd0);
        chk("ar_busy",  96'(busy0), 96'd0);
        chk("ar_rdy",   96'(rdy0), 96'd1);
        chk("ar_data",  {a0, b0, c0}, 96'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int s = 0; s < 30; s++) begin
            step(1'b0, '0);
            if (vld0 || vld1) pulses++;
        end
        chk("ar_no_stale", 96'(pulses), 96'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int s = 0; s < 400; s++)
            step($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom});
        for (int s = 0; s < 100; s++)
            step(1'b0, '0);
        chk("rnd_drained", 96'(busy0 || busy1), 96'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
